// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - M stage: EX/M register, ready/valid data-memory port, sub-word load formatting
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   stall_M, flush_M      hazard-unit hold / bubble-insert for the EX/M register
//   buffIn_M              EX/M bundle {regWrite, memToReg, memWrite, memRead, memSize[1:0],
//                         memUnsigned, aluOut, writeData, writeReg[4:0], instr}
//   dmem_*                data-memory request side (req/we/addr/be/wdata, ready)
//                         and response side (rvalid/rdata)
//   busy_M                access still outstanding; stalls the upstream stages
//   misalign_M            current memory instruction is misaligned (access suppressed)
//   regWrite_M, writeReg_M, aluOut_M   forwarding taps
//   buffOut_M             {regWrite, memToReg, readData, aluOut, writeReg[4:0], instr} to write-back
module mem_access_stage #(
    parameter int width = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall_M,
    input  logic                 flush_M,
    input  logic [3*width+11:0]  buffIn_M,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [width-1:0]     dmem_addr,
    output logic [3:0]           dmem_be,
    output logic [width-1:0]     dmem_wdata,
    input  logic                 dmem_ready,
    input  logic                 dmem_rvalid,
    input  logic [width-1:0]     dmem_rdata,
    output logic                 busy_M,
    output logic                 misalign_M,
    output logic                 regWrite_M,
    output logic [4:0]           writeReg_M,
    output logic [width-1:0]     aluOut_M,
    output logic [3*width+6:0]   buffOut_M
);

    typedef enum logic [1:0] {IDLE, WAIT_ACC, WAIT_RD, DONE} state_t;

    state_t                state_q;
    state_t                state_d;
    logic [3*width+11:0]   ex_q;
    logic [width-1:0]      rdata_q;

    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  mem_write;
    logic                  mem_read;
    logic [1:0]            mem_size;
    logic                  mem_unsigned;
    logic [width-1:0]      alu_out;
    logic [width-1:0]      write_data;
    logic [4:0]            write_reg;
    logic [width-1:0]      instr;

    logic                  access;
    logic                  done;
    logic                  load_done;
    logic [3:0]            be_raw;
    logic [width-1:0]      wdata_raw;
    logic [width-1:0]      load_src;
    logic [7:0]            lane_b;
    logic [15:0]           lane_h;
    logic [width-1:0]      load_fmt;
    logic [width-1:0]      read_data;

    // EX/M register field decode
    assign reg_write    = ex_q[3*width+11];
    assign mem_to_reg   = ex_q[3*width+10];
    assign mem_write    = ex_q[3*width+9];
    assign mem_read     = ex_q[3*width+8];
    assign mem_size     = ex_q[3*width+7 -: 2];
    assign mem_unsigned = ex_q[3*width+5];
    assign alu_out      = ex_q[3*width+4 -: width];
    assign write_data   = ex_q[2*width+4 -: width];
    assign write_reg    = ex_q[width+4 -: 5];
    assign instr        = ex_q[width-1:0];

    // memSize 1x is a word; half needs bit 0 clear, word needs both low bits clear
    always_comb begin
        misalign_M = 1'b0;
        if (mem_read | mem_write) begin
            if (mem_size[1])
                misalign_M = (alu_out[1:0] != 2'b00);
            else if (mem_size[0])
                misalign_M = alu_out[0];
        end
    end

    assign access = (mem_read | mem_write) & ~misalign_M;

    // EX/M register: flush beats hold, and hold covers our own outstanding access
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ex_q <= '0;
        else if (flush_M)
            ex_q <= '0;
        else if (!(stall_M | busy_M))
            ex_q <= buffIn_M;
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // FSM next state; a completed access parks in DONE while the stage is held
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, WAIT_ACC: begin
                if (!access)
                    state_d = IDLE;
                else if (!dmem_ready)
                    state_d = WAIT_ACC;
                else if (done)
                    state_d = stall_M ? DONE : IDLE;
                else
                    state_d = WAIT_RD;
            end
            WAIT_RD: begin
                if (dmem_rvalid)
                    state_d = stall_M ? DONE : IDLE;
            end
            DONE: begin
                if (!stall_M)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; the request is only driven before acceptance, so a held
    // instruction never issues a second one
    always_comb begin
        dmem_req = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE, WAIT_ACC: begin
                dmem_req = access;
                done     = dmem_ready & (mem_write | dmem_rvalid);
            end
            WAIT_RD: done = dmem_rvalid;
            DONE:    done = 1'b1;
            default: ;
        endcase
        busy_M = access & ~done;
    end

    // Keep the returned word so a stalled instruction still presents it
    assign load_done = access & ~mem_write & done & (state_q != DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rdata_q <= '0;
        else if (load_done)
            rdata_q <= dmem_rdata;
    end

    // Store lane enables and lane-replicated write data
    always_comb begin
        case (mem_size)
            2'b00: begin
                be_raw    = 4'b0001 << alu_out[1:0];
                wdata_raw = {4{write_data[7:0]}};
            end
            2'b01: begin
                be_raw    = alu_out[1] ? 4'b1100 : 4'b0011;
                wdata_raw = {2{write_data[15:0]}};
            end
            default: begin
                be_raw    = 4'b1111;
                wdata_raw = write_data;
            end
        endcase
    end

    assign dmem_we    = access & mem_write;
    assign dmem_addr  = {alu_out[width-1:2], 2'b00};
    assign dmem_be    = access ? be_raw : 4'b0000;
    assign dmem_wdata = access ? wdata_raw : '0;

    // Load lane select and sign/zero extension
    always_comb begin
        load_src = (state_q == DONE) ? rdata_q : dmem_rdata;
        case (alu_out[1:0])
            2'b00:   lane_b = load_src[7:0];
            2'b01:   lane_b = load_src[15:8];
            2'b10:   lane_b = load_src[23:16];
            default: lane_b = load_src[31:24];
        endcase
        lane_h = alu_out[1] ? load_src[31:16] : load_src[15:0];
        case (mem_size)
            2'b00:   load_fmt = {{(width-8){~mem_unsigned & lane_b[7]}}, lane_b};
            2'b01:   load_fmt = {{(width-16){~mem_unsigned & lane_h[15]}}, lane_h};
            default: load_fmt = load_src;
        endcase
        read_data = (access & mem_read) ? load_fmt : '0;
    end

    assign regWrite_M = reg_write & ~misalign_M;
    assign writeReg_M = write_reg;
    assign aluOut_M   = alu_out;

    // regWrite is dropped while busy so write-back sees a bubble until completion
    assign buffOut_M = {regWrite_M & ~busy_M, mem_to_reg, read_data, alu_out, write_reg, instr};

endmodule
